// File: rtl/uart_tx_chan_mux.sv
// uart_tx_chan_mux
//   N:1 channel multiplexer with valid/ready handshaking in front of the UART
//   TX serializer. One channel is granted per cycle, either by the external
//   select (mode=0) or by round-robin arbitration (mode=1). The granted word
//   is captured in a single-entry output register, tagged with its source
//   channel, and drained by the serializer through out_valid/out_ready.
//
// Build option
//   CHMUX_BURST_EN : when defined, a round-robin winner keeps the grant for
//                    up to BURST consecutive transfers while its in_valid
//                    stays high. When undefined the grant rotates after every
//                    transfer and BURST has no effect.
//
// Ports
//   clk        clock, rising edge
//   rst        synchronous active-high reset; overrides all other inputs
//   enable     1: words may be accepted; 0: no accepts, output still drains
//   mode       0: fixed select by sel; 1: round-robin
//   sel        channel index used when mode=0
//   in_data    channel i word at [i*WIDTH +: WIDTH]
//   in_valid   per-channel word available
//   in_ready   per-channel accept (combinational)
//   out_data   registered output word
//   out_valid  output register holds a word
//   out_ready  downstream takes out_data this cycle
//   out_chan   source channel of the word in out_data

module uart_tx_chan_mux #(
    parameter int  WIDTH    = 32,
    parameter int  CHANNELS = 4,
    parameter int  BURST    = 4,
    localparam int SEL_W    = $clog2(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      enable,
    input  logic                      mode,
    input  logic [SEL_W-1:0]          sel,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic [CHANNELS-1:0]       in_valid,
    output logic [CHANNELS-1:0]       in_ready,
    output logic [WIDTH-1:0]          out_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [SEL_W-1:0]          out_chan
);

    if (CHANNELS < 2 || BURST < 1) begin : g_param_check
        $error("uart_tx_chan_mux: CHANNELS must be >= 2 and BURST >= 1");
    end

    // Unpack the flat input bus so the granted word is a plain array read.
    logic [WIDTH-1:0] ch_data [CHANNELS];
    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_unpack
        assign ch_data[gi] = in_data[gi*WIDTH +: WIDTH];
    end

    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             out_valid_q, out_valid_d;
    logic [SEL_W-1:0] out_chan_q, out_chan_d;
    logic [SEL_W-1:0] rr_ptr_q, rr_ptr_d;

    logic [SEL_W-1:0] grant;
    logic [SEL_W-1:0] rr_base;
    logic             grant_vld;
    logic             out_free;
    logic             accept;
    logic             load;

`ifdef CHMUX_BURST_EN
    localparam int CNT_W = $clog2(BURST + 1);
    logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d, cnt_inc;
    logic [SEL_W-1:0] holder_q, holder_d;
    logic             burst_active, burst_keep, burst_drop;
`endif

    // First requester after 'base', wrapping modulo CHANNELS. Scanning from
    // the far end lets the nearest requester overwrite the result last.
    function automatic logic [SEL_W-1:0] rr_scan(input logic [SEL_W-1:0]    base,
                                                 input logic [CHANNELS-1:0] req);
        int idx;
        rr_scan = '0;
        for (int k = CHANNELS; k >= 1; k--) begin
            idx = int'(base) + k;
            if (idx >= CHANNELS) idx = idx - CHANNELS;
            if (req[idx[SEL_W-1:0]]) rr_scan = SEL_W'(idx);
        end
    endfunction

    // Grant selection and handshake.
    always_comb begin
        out_free  = !out_valid_q || out_ready;
        grant     = '0;
        grant_vld = 1'b0;
        rr_base   = rr_ptr_q;
`ifdef CHMUX_BURST_EN
        burst_active = (burst_cnt_q != '0);
        burst_keep   = burst_active && in_valid[holder_q];
        burst_drop   = burst_active && !in_valid[holder_q];
        // A burst cut short by the holder resumes arbitration after the holder.
        if (burst_drop) rr_base = holder_q;
`endif
        if (mode) begin
            grant_vld = |in_valid;
            grant     = rr_scan(rr_base, in_valid);
`ifdef CHMUX_BURST_EN
            if (burst_keep) grant = holder_q;
`endif
        end else begin
            // Zero-extended compare keeps out-of-range selects silently idle.
            grant_vld = ({{(32-SEL_W){1'b0}}, sel} < 32'(CHANNELS));
            grant     = sel;
        end
        accept = !rst && enable && grant_vld && out_free;
        load   = accept && in_valid[grant];
    end

    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ready
        assign in_ready[gi] = accept && (grant == SEL_W'(gi));
    end

    // Next-state logic for the output stage and arbitration state.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_chan_d  = out_chan_q;
        rr_ptr_d    = rr_ptr_q;

        if (load) begin
            out_valid_d = 1'b1;
            out_data_d  = ch_data[grant];
            out_chan_d  = grant;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

`ifdef CHMUX_BURST_EN
        burst_cnt_d = burst_cnt_q;
        holder_d    = holder_q;
        cnt_inc     = burst_keep ? burst_cnt_q + 1'b1 : CNT_W'(1);
        if (enable && mode) begin
            if (load) begin
                if (burst_drop) rr_ptr_d = holder_q;
                if (cnt_inc == CNT_W'(BURST)) begin
                    burst_cnt_d = '0;
                    rr_ptr_d    = grant;
                end else begin
                    burst_cnt_d = cnt_inc;
                    holder_d    = grant;
                end
            end else if (burst_drop) begin
                burst_cnt_d = '0;
                rr_ptr_d    = holder_q;
            end
        end
`else
        if (load && mode) rr_ptr_d = grant;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_chan_q  <= '0;
            rr_ptr_q    <= SEL_W'(CHANNELS - 1);
`ifdef CHMUX_BURST_EN
            burst_cnt_q <= '0;
            holder_q    <= '0;
`endif
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_chan_q  <= out_chan_d;
            rr_ptr_q    <= rr_ptr_d;
`ifdef CHMUX_BURST_EN
            burst_cnt_q <= burst_cnt_d;
            holder_q    <= holder_d;
`endif
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_chan  = out_chan_q;

endmodule

// File: tb/tb_uart_tx_chan_mux.sv
// Testbench for uart_tx_chan_mux: directed scenarios followed by random
// traffic, all checked against a cycle-level behavioural model.
module tb_uart_tx_chan_mux;
    localparam int W     = 32;
    localparam int CH    = 4;
    localparam int BURST = 2;

    logic          clk = 1'b0;
    logic          rst, enable, mode, out_ready, out_valid;
    logic [1:0]    sel, out_chan;
    logic [CH*W-1:0] in_data;
    logic [CH-1:0] in_valid, in_ready;
    logic [W-1:0]  out_data;

    int checks   = 0;
    int failures = 0;

    // Behavioural model state.
    logic         m_valid = 1'b0;
    logic [W-1:0] m_data  = '0;
    int           m_chan  = 0;
    int           m_rr    = CH - 1;
    int           m_cnt   = 0;
    int           m_hold  = 0;

    uart_tx_chan_mux #(.WIDTH(W), .CHANNELS(CH), .BURST(BURST)) dut (
        .clk(clk), .rst(rst), .enable(enable), .mode(mode), .sel(sel),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_chan(out_chan)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Which channel the specification's rules grant right now.
    task automatic model_grant(output bit gv, output int g);
        int base;
        gv = 1'b0;
        g  = 0;
        if (!mode) begin
            gv = (int'(sel) < CH);
            g  = int'(sel);
        end else begin
            gv   = |in_valid;
            base = m_rr;
`ifdef CHMUX_BURST_EN
            if (m_cnt > 0) begin
                if (in_valid[m_hold]) begin
                    g = m_hold;
                    return;
                end
                base = m_hold;
            end
`endif
            for (int k = 1; k <= CH; k++) begin
                if (in_valid[(base + k) % CH]) begin
                    g = (base + k) % CH;
                    break;
                end
            end
        end
    endtask

    // One clock cycle with the inputs currently driven: check the
    // combinational ready, advance the model at the edge, check outputs.
    task automatic cyc();
        bit          gv, xfer;
        int          g, n;
        logic [CH-1:0] exp_rdy;
        logic [W-1:0]  word;
        #1;
        model_grant(gv, g);
        exp_rdy = '0;
        if (!rst && enable && gv && (!m_valid || out_ready)) exp_rdy[g] = 1'b1;
        check("in_ready", 64'(in_ready), 64'(exp_rdy));
        xfer = exp_rdy[g] && in_valid[g];
        word = in_data[g*W +: W];
        @(posedge clk);
        if (rst) begin
            m_valid = 1'b0; m_data = '0; m_chan = 0;
            m_rr = CH - 1; m_cnt = 0; m_hold = 0;
        end else begin
            if (xfer) begin
                m_valid = 1'b1; m_data = word; m_chan = g;
                $display("t=%0t xfer ch=%0d data=%08h", $time, g, word);
            end else if (m_valid && out_ready) begin
                m_valid = 1'b0;
            end
            if (enable && mode) begin
`ifdef CHMUX_BURST_EN
                if (xfer) begin
                    if (m_cnt > 0 && g == m_hold && in_valid[m_hold]) n = m_cnt + 1;
                    else begin
                        if (m_cnt > 0) m_rr = m_hold;
                        n = 1;
                    end
                    if (n >= BURST) begin m_cnt = 0; m_rr = g; end
                    else begin m_cnt = n; m_hold = g; end
                end else if (m_cnt > 0 && !in_valid[m_hold]) begin
                    m_cnt = 0; m_rr = m_hold;
                end
`else
                if (xfer) m_rr = g;
`endif
            end
        end
        #1;
        check("out_valid", 64'(out_valid), 64'(m_valid));
        check("out_chan",  64'(out_chan),  64'(m_chan));
        check("out_data",  64'(out_data),  64'(m_data));
    endtask

    int t4_exp [8];
    int t5_exp [4];

    initial begin
`ifdef CHMUX_BURST_EN
        t4_exp = '{0, 0, 1, 1, 2, 2, 3, 3};
        t5_exp = '{1, 1, 3, 3};
`else
        t4_exp = '{0, 1, 2, 3, 0, 1, 2, 3};
        t5_exp = '{1, 3, 1, 3};
`endif
        // T1: reset with every channel requesting.
        rst = 1'b1; enable = 1'b1; mode = 1'b0; sel = 2'd0; out_ready = 1'b1;
        in_valid = 4'b1111;
        for (int i = 0; i < CH; i++) in_data[i*W +: W] = 32'hA5A5_0000 + 32'(i);
        cyc(); cyc();
        check("t1_valid", 64'(out_valid), 64'd0);
        check("t1_data",  64'(out_data),  64'd0);

        // T2: fixed select of channel 2.
        rst = 1'b0; sel = 2'd2;
        #1;
        check("t2_ready", 64'(in_ready), 64'b0100);
        cyc();
        check("t2_data", 64'(out_data), 64'hA5A5_0002);
        check("t2_chan", 64'(out_chan), 64'd2);

        // T3: backpressure holds the word, then drain+reload with no bubble.
        out_ready = 1'b0;
        in_data[2*W +: W] = 32'h1111_2222;
        for (int i = 0; i < 5; i++) cyc();
        check("t3_held", 64'(out_data), 64'hA5A5_0002);
        out_ready = 1'b1;
        cyc();
        check("t3_reload_valid", 64'(out_valid), 64'd1);
        check("t3_reload_data",  64'(out_data),  64'h1111_2222);

        // T4: round-robin with all channels valid.
        rst = 1'b1; cyc(); rst = 1'b0;
        mode = 1'b1; in_valid = 4'b1111;
        for (int i = 0; i < 8; i++) begin
            cyc();
            check("t4_seq", 64'(out_chan), 64'(t4_exp[i]));
        end

        // T5: sparse requesters with wrap-around.
        rst = 1'b1; cyc(); rst = 1'b0;
        in_valid = 4'b1010;
        for (int i = 0; i < 4; i++) begin
            cyc();
            check("t5_seq", 64'(out_chan), 64'(t5_exp[i]));
        end

        // T6: enable low drains without accepting; reset drops a held word.
        rst = 1'b1; cyc(); rst = 1'b0;
        mode = 1'b0; sel = 2'd1; in_valid = 4'b0010; out_ready = 1'b0;
        cyc();
        enable = 1'b0;
        #1;
        check("t6_no_accept", 64'(in_ready), 64'd0);
        cyc();
        check("t6_held", 64'(out_valid), 64'd1);
        out_ready = 1'b1;
        cyc();
        check("t6_drained", 64'(out_valid), 64'd0);
        cyc();
        check("t6_still_empty", 64'(out_valid), 64'd0);
        enable = 1'b1;
        cyc();
        check("t6_reloaded", 64'(out_valid), 64'd1);
        out_ready = 1'b0; rst = 1'b1;
        cyc();
        check("t6_rst_drop", 64'(out_valid), 64'd0);
        rst = 1'b0;

        // Random traffic against the model.
        for (int n = 0; n < 400; n++) begin
            rst       = ($urandom_range(0, 49) == 0);
            enable    = ($urandom_range(0, 9) < 8);
            if ($urandom_range(0, 15) == 0) mode = ~mode;
            sel       = 2'($urandom_range(0, 3));
            in_valid  = 4'($urandom_range(0, 15));
            out_ready = ($urandom_range(0, 9) < 7);
            for (int i = 0; i < CH; i++) in_data[i*W +: W] = $urandom;
            cyc();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
